mul_result_stage: RTL and testbench

MUL_RESULT_STAGE -- requirements
Module: mul_result_stage

---
 rtl/mul_result_stage_if.sv | 24 ++
 rtl/mul_result_stage.sv | 102 ++++++++++
 tb/tb_mul_result_stage.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mul_result_stage_if.sv
// Handshake bundle between the Booth multiplier, the result stage and the result consumer.
// The slave modport is the view used by mul_result_stage itself.
interface mul_result_stage_if;
   logic        prod_valid;
   logic [66:0] prod;
   logic [1:0]  mode;
   logic        prod_ready;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_last;
   logic        out_ovf;
   logic [2:0]  count;

   modport master (
      output prod_valid, prod, mode, out_ready,
      input  prod_ready, out_valid, out_data, out_last, out_ovf, count
   );

   modport slave (
      input  prod_valid, prod, mode, out_ready,
      output prod_ready, out_valid, out_data, out_last, out_ovf, count
   );
endinterface

// File: rtl/mul_result_stage.sv
// Buffers 67-bit Booth products in a small circular FIFO and emits them as formatted
// 32-bit beats (low, high, low+high, or saturated), with a per-entry overflow flag.
module mul_result_stage #(
   parameter int DEPTH = 2
) (
   input logic                clk,
   input logic                rst_b,
   mul_result_stage_if.slave  bus
);

   localparam int             PW       = (DEPTH > 2) ? 2 : 1;
   localparam logic [PW-1:0]  LAST_IDX = PW'(DEPTH - 1);
   localparam logic [2:0]     FULL_CNT = 3'(DEPTH);

   localparam logic [1:0] EMPTY   = 2'd0;
   localparam logic [1:0] BEAT_LO = 2'd1;
   localparam logic [1:0] BEAT_HI = 2'd2;

   logic [66:0]   mem_prod [DEPTH];
   logic [1:0]    mem_mode [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr, wr_inc, rd_inc, rd_next;
   logic [2:0]    count_q, count_d;
   logic [1:0]    state, state_d, after_pop;
   logic          push, pop, beat_take;
   logic [66:0]   head_prod;
   logic [1:0]    head_mode, next_head_mode;
   logic [35:0]   head_top;
   logic          head_ovf;
   logic [31:0]   head_sat;

   assign head_prod = mem_prod[rd_ptr];
   assign head_mode = mem_mode[rd_ptr];
   assign head_top  = head_prod[66:31];
   assign head_ovf  = !((&head_top) || !(|head_top));
   assign head_sat  = head_ovf ? (head_prod[66] ? 32'h8000_0000 : 32'h7FFF_FFFF)
                               : head_prod[31:0];

   // Ready comes purely from the registered fill level, so a full buffer never
   // accepts in the same cycle as a pop.
   assign bus.prod_ready = (count_q < FULL_CNT);
   assign push           = bus.prod_valid && bus.prod_ready;

   assign bus.out_valid = (state != EMPTY);
   assign bus.out_last  = (state == BEAT_HI) || ((state == BEAT_LO) && (head_mode != 2'b10));
   assign bus.out_ovf   = bus.out_valid && head_ovf;
   assign bus.count     = count_q;

   assign beat_take = bus.out_valid && bus.out_ready;
   assign pop       = beat_take && bus.out_last;

   assign wr_inc  = (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
   assign rd_inc  = (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
   assign rd_next = pop ? rd_inc : rd_ptr;
   assign count_d = count_q + 3'(push) - 3'(pop);

   // After a pop the new head may be the entry being written this very cycle.
   assign next_head_mode = (push && (wr_ptr == rd_next)) ? bus.mode : mem_mode[rd_next];
   assign after_pop      = (count_d == 3'd0) ? EMPTY :
                           ((next_head_mode == 2'b01) ? BEAT_HI : BEAT_LO);

   always_comb begin
      state_d = state;
      case (state)
         EMPTY:   if (count_q != 3'd0) state_d = (head_mode == 2'b01) ? BEAT_HI : BEAT_LO;
         BEAT_LO: if (beat_take)       state_d = bus.out_last ? after_pop : BEAT_HI;
         BEAT_HI: if (beat_take)       state_d = after_pop;
         default:                      state_d = EMPTY;
      endcase
   end

   always_comb begin
      bus.out_data = 32'h0;
      case (state)
         BEAT_LO: bus.out_data = (head_mode == 2'b11) ? head_sat : head_prod[31:0];
         BEAT_HI: bus.out_data = head_prod[63:32];
         default: bus.out_data = 32'h0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= 3'd0;
         state   <= EMPTY;
         for (int i = 0; i < DEPTH; i++) begin
            mem_prod[i] <= '0;
            mem_mode[i] <= '0;
         end
      end else begin
         if (push) begin
            mem_prod[wr_ptr] <= bus.prod;
            mem_mode[wr_ptr] <= bus.mode;
            wr_ptr           <= wr_inc;
         end
         rd_ptr  <= rd_next;
         count_q <= count_d;
         state   <= state_d;
      end
   end

endmodule

// File: tb/tb_mul_result_stage.sv
// Directed bench for mul_result_stage: a vector table for single-entry formatting plus
// sequences for backpressure, reset mid-transfer and back-to-back streaming.
module tb_mul_result_stage;

   logic clk;
   logic rst_b;
   int   total;
   int   bad;

   mul_result_stage_if bus ();

   mul_result_stage #(.DEPTH(2)) dut (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [66:0] prod;
      logic [1:0]  mode;
      int          beats;
      logic [31:0] d0;
      logic        last0;
      logic [31:0] d1;
      logic        ovf;
   } vec_t;

   localparam int NV = 10;
   vec_t vecs [NV];

   task automatic applyStimulus(input logic v, input logic [66:0] p, input logic [1:0] m,
                                input logic rdy);
      bus.prod_valid = v;
      bus.prod       = p;
      bus.mode       = m;
      bus.out_ready  = rdy;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;

      vecs[0] = '{67'd6408,                        2'b00, 1, 32'h0000_1908, 1'b1, 32'h0,         1'b0};
      vecs[1] = '{{67{1'b1}},                      2'b10, 2, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0};
      vecs[2] = '{67'd1 << 40,                     2'b11, 1, 32'h7FFF_FFFF, 1'b1, 32'h0,         1'b1};
      vecs[3] = '{67'd0 - (67'd1 << 40),           2'b11, 1, 32'h8000_0000, 1'b1, 32'h0,         1'b1};
      vecs[4] = '{67'd1 << 40,                     2'b01, 1, 32'h0000_0100, 1'b1, 32'h0,         1'b1};
      vecs[5] = '{67'h1_2345_6789_ABCD,            2'b10, 2, 32'h6789_ABCD, 1'b0, 32'h0001_2345, 1'b1};
      vecs[6] = '{67'd0 - 67'd5,                   2'b11, 1, 32'hFFFF_FFFB, 1'b1, 32'h0,         1'b0};
      vecs[7] = '{67'h7FFF_FFFF,                   2'b11, 1, 32'h7FFF_FFFF, 1'b1, 32'h0,         1'b0};
      vecs[8] = '{67'h8000_0000,                   2'b11, 1, 32'h7FFF_FFFF, 1'b1, 32'h0,         1'b1};
      vecs[9] = '{67'd0 - 67'h8000_0000,           2'b11, 1, 32'h8000_0000, 1'b1, 32'h0,         1'b0};

      // Reset state, then release and confirm the stage is ready and idle.
      rst_b = 1'b0;
      applyStimulus(1'b0, '0, 2'b00, 1'b1);
      @(negedge clk);
      checkOutput("rst_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("rst_data",  bus.out_data,       32'd0);
      checkOutput("rst_last",  32'(bus.out_last),  32'd0);
      checkOutput("rst_ovf",   32'(bus.out_ovf),   32'd0);
      checkOutput("rst_count", 32'(bus.count),     32'd0);
      rst_b = 1'b1;
      @(negedge clk);
      checkOutput("rel_ready", 32'(bus.prod_ready), 32'd1);

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         applyStimulus(1'b1, vecs[i].prod, vecs[i].mode, 1'b1);
         @(negedge clk);
         applyStimulus(1'b0, '0, 2'b00, 1'b1);
         checkOutput($sformatf("v%0d_early_valid", i), 32'(bus.out_valid), 32'd0);
         checkOutput($sformatf("v%0d_count1", i),      32'(bus.count),     32'd1);
         @(negedge clk);
         checkOutput($sformatf("v%0d_valid0", i), 32'(bus.out_valid), 32'd1);
         checkOutput($sformatf("v%0d_data0", i),  bus.out_data,       vecs[i].d0);
         checkOutput($sformatf("v%0d_last0", i),  32'(bus.out_last),  32'(vecs[i].last0));
         checkOutput($sformatf("v%0d_ovf0", i),   32'(bus.out_ovf),   32'(vecs[i].ovf));
         if (vecs[i].beats == 2) begin
            @(negedge clk);
            checkOutput($sformatf("v%0d_valid1", i), 32'(bus.out_valid), 32'd1);
            checkOutput($sformatf("v%0d_data1", i),  bus.out_data,       vecs[i].d1);
            checkOutput($sformatf("v%0d_last1", i),  32'(bus.out_last),  32'd1);
            checkOutput($sformatf("v%0d_ovf1", i),   32'(bus.out_ovf),   32'(vecs[i].ovf));
         end
         @(negedge clk);
         checkOutput($sformatf("v%0d_idle_valid", i), 32'(bus.out_valid), 32'd0);
         checkOutput($sformatf("v%0d_idle_data", i),  bus.out_data,       32'd0);
         checkOutput($sformatf("v%0d_idle_count", i), 32'(bus.count),     32'd0);
      end

      // Backpressure: three pushes into a two-entry buffer, then drain in order.
      @(negedge clk);
      applyStimulus(1'b1, 67'd11, 2'b00, 1'b0);
      checkOutput("bp_ready0", 32'(bus.prod_ready), 32'd1);
      @(negedge clk);
      applyStimulus(1'b1, 67'd22, 2'b00, 1'b0);
      @(negedge clk);
      applyStimulus(1'b1, 67'd33, 2'b00, 1'b0);
      checkOutput("bp_count_full", 32'(bus.count),      32'd2);
      checkOutput("bp_ready_full", 32'(bus.prod_ready), 32'd0);
      checkOutput("bp_data_a",     bus.out_data,        32'd11);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checkOutput($sformatf("bp_hold_count%0d", k), 32'(bus.count),      32'd2);
         checkOutput($sformatf("bp_hold_ready%0d", k), 32'(bus.prod_ready), 32'd0);
         checkOutput($sformatf("bp_hold_data%0d", k),  bus.out_data,        32'd11);
         checkOutput($sformatf("bp_hold_last%0d", k),  32'(bus.out_last),   32'd1);
      end
      applyStimulus(1'b1, 67'd33, 2'b00, 1'b1);
      @(negedge clk);
      checkOutput("bp_drain_b",     bus.out_data,        32'd22);
      checkOutput("bp_drain_count", 32'(bus.count),      32'd1);
      checkOutput("bp_drain_ready", 32'(bus.prod_ready), 32'd1);
      @(negedge clk);
      applyStimulus(1'b0, '0, 2'b00, 1'b1);
      checkOutput("bp_drain_c",       bus.out_data,   32'd33);
      checkOutput("bp_drain_c_count", 32'(bus.count), 32'd1);
      @(negedge clk);
      checkOutput("bp_done_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("bp_done_count", 32'(bus.count),     32'd0);

      // Reset while the high beat of a two-beat entry is pending.
      @(negedge clk);
      applyStimulus(1'b1, 67'h0000_000A_0000_000B, 2'b10, 1'b1);
      @(negedge clk);
      applyStimulus(1'b0, '0, 2'b00, 1'b1);
      @(negedge clk);
      checkOutput("mr_beat_lo", bus.out_data,      32'h0000_000B);
      checkOutput("mr_last_lo", 32'(bus.out_last), 32'd0);
      @(negedge clk);
      checkOutput("mr_beat_hi", bus.out_data, 32'h0000_000A);
      rst_b = 1'b0;
      #1;
      checkOutput("mr_rst_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("mr_rst_data",  bus.out_data,       32'd0);
      checkOutput("mr_rst_last",  32'(bus.out_last),  32'd0);
      checkOutput("mr_rst_count", 32'(bus.count),     32'd0);
      @(negedge clk);
      rst_b = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput($sformatf("mr_after_valid%0d", k), 32'(bus.out_valid), 32'd0);
         checkOutput($sformatf("mr_after_data%0d", k),  bus.out_data,       32'd0);
      end

      // Streaming: one entry primed, then push and pop every cycle.
      @(negedge clk);
      applyStimulus(1'b1, 67'd100, 2'b00, 1'b1);
      @(negedge clk);
      applyStimulus(1'b0, '0, 2'b00, 1'b1);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         checkOutput($sformatf("st_valid%0d", k), 32'(bus.out_valid), 32'd1);
         checkOutput($sformatf("st_data%0d", k),  bus.out_data,       32'(99 + k));
         checkOutput($sformatf("st_count%0d", k), 32'(bus.count),     32'd1);
         applyStimulus(1'b1, 67'(100 + k), 2'b00, 1'b1);
      end
      @(negedge clk);
      applyStimulus(1'b0, '0, 2'b00, 1'b1);
      checkOutput("st_tail_data", bus.out_data, 32'd106);
      @(negedge clk);
      checkOutput("st_end_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("st_end_count", 32'(bus.count),     32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
